elevator_controller: RTL



---
 rtl/elevator_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_controller
//  Purpose  : Collective (SCAN) car sequencer with travel/door timing and an
//             emergency hold state. Optional home-return feature: HOME_RETURN_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_controller #(
  parameter int  NUM_FLOORS       = 8,
  parameter int  TRAVEL_CYCLES    = 100,
  parameter int  DOOR_CYCLES      = 50,
  parameter int  HOME_IDLE_CYCLES = 500,
  localparam int FLOOR_W          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req_i,
  input  logic                  sos_mode_i,
  input  logic                  weight_limit_exceeded_i,
  output logic [FLOOR_W-1:0]    floor_o,
  output logic                  door_o,
  output logic                  moving_up_o,
  output logic                  moving_down_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  emergency_o
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC);

  if (NUM_FLOORS < 2 || TRAVEL_CYCLES < 2 || DOOR_CYCLES < 2 || HOME_IDLE_CYCLES < 1) begin : g_param_check
    $error("elevator_controller: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_DOOR   = 2'd2,
    S_EMERG  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  door_q, door_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  emerg_q, emerg_d;
  logic                  dir_up_q, dir_up_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  logic                  w_any_above, w_any_below;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic                  w_home_fire;

  always_comb begin
    w_any_above = 1'b0;
    w_any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q)) w_any_above = w_any_above | pending_q[i];
      if (i < int'(floor_q)) w_any_below = w_any_below | pending_q[i];
    end
  end

  assign w_floor_nxt = up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

`ifdef HOME_RETURN_EN
  localparam int HOME_W = $clog2(HOME_IDLE_CYCLES + 1);
  logic [HOME_W-1:0] home_cnt_q, home_cnt_d;

  always_comb begin
    home_cnt_d  = '0;
    w_home_fire = 1'b0;
    if (state_q == S_IDLE && pending_q == '0 && call_req_i == '0 &&
        floor_q != '0 && !sos_mode_i) begin
      if (home_cnt_q == HOME_W'(HOME_IDLE_CYCLES - 1)) w_home_fire = 1'b1;
      else                                             home_cnt_d  = home_cnt_q + HOME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) home_cnt_q <= '0;
    else        home_cnt_q <= home_cnt_d;
  end
`else
  assign w_home_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    door_d    = door_q;
    up_d      = 1'b0;
    down_d    = 1'b0;
    emerg_d   = 1'b0;
    dir_up_d  = dir_up_q;
    timer_d   = '0;
    pending_d = pending_q | call_req_i;
    case (state_q)
      S_IDLE: begin
        door_d = 1'b0;
        if (sos_mode_i) begin
          state_d   = S_EMERG;
          door_d    = 1'b1;
          emerg_d   = 1'b1;
          pending_d = '0;
        end else if (pending_q[floor_q]) begin
          state_d            = S_DOOR;
          door_d             = 1'b1;
          pending_d[floor_q] = 1'b0;
        end else if (w_any_above && (dir_up_q || !w_any_below)) begin
          state_d  = S_MOVING;
          up_d     = 1'b1;
          dir_up_d = 1'b1;
        end else if (w_any_below) begin
          state_d  = S_MOVING;
          down_d   = 1'b1;
          dir_up_d = 1'b0;
        end else if (w_home_fire) begin
          pending_d[0] = 1'b1;
        end
      end
      S_MOVING: begin
        up_d   = up_q;
        down_d = down_q;
        if (timer_q == TIMER_W'(TRAVEL_CYCLES - 1)) begin
          floor_d = w_floor_nxt;
          if (sos_mode_i) begin
            state_d   = S_EMERG;
            up_d      = 1'b0;
            down_d    = 1'b0;
            door_d    = 1'b1;
            emerg_d   = 1'b1;
            pending_d = '0;
          end else if (pending_d[w_floor_nxt]) begin
            state_d                = S_DOOR;
            up_d                   = 1'b0;
            down_d                 = 1'b0;
            door_d                 = 1'b1;
            pending_d[w_floor_nxt] = 1'b0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DOOR: begin
        door_d = 1'b1;
        // A call at the open floor re-arms the dwell instead of being latched.
        pending_d[floor_q] = pending_q[floor_q];
        if (sos_mode_i) begin
          state_d   = S_EMERG;
          emerg_d   = 1'b1;
          pending_d = '0;
        end else if (timer_q == TIMER_W'(DOOR_CYCLES - 1) && weight_limit_exceeded_i) begin
          timer_d = timer_q;
        end else if (call_req_i[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == TIMER_W'(DOOR_CYCLES - 1)) begin
          state_d = S_IDLE;
          door_d  = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_EMERG: begin
        pending_d = '0;
        if (sos_mode_i) begin
          door_d  = 1'b1;
          emerg_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          door_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      door_q    <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      emerg_q   <= 1'b0;
      dir_up_q  <= 1'b1;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      door_q    <= door_d;
      up_q      <= up_d;
      down_q    <= down_d;
      emerg_q   <= emerg_d;
      dir_up_q  <= dir_up_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign floor_o       = floor_q;
  assign door_o        = door_q;
  assign moving_up_o   = up_q;
  assign moving_down_o = down_q;
  assign pending_o     = pending_q;
  assign emergency_o   = emerg_q;

endmodule
`default_nettype wire
